// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - RV32I memory stage with ready/valid data port and MEM/WB register
module memory_access_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_write_m,
    input  logic [1:0]  result_src_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] write_data_m,
    input  logic [4:0]  rd_m,
    input  logic [31:0] pc_plus_4_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m,
    output logic        misaligned_m,
    output logic        reg_write_w,
    output logic [1:0]  result_src_w,
    output logic [31:0] alu_result_w,
    output logic [31:0] read_data_w,
    output logic [31:0] pc_plus_4_w,
    output logic [4:0]  rd_w
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  state;
    logic [1:0]  a;
    logic        access;
    logic        is_load;
    logic        misaligned;
    logic        active;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign a       = alu_result_m[1:0];
    assign access  = (result_src_m == 2'b01) || mem_write_m;
    // a load that also asserts mem_write is handled as a store
    assign is_load = (result_src_m == 2'b01) && !mem_write_m;
    assign misaligned = access &&
                        (((funct3_m[1:0] == 2'b01) && a[0]) ||
                         ((funct3_m[1:0] == 2'b10) && (a != 2'b00)));

    // inputs are held by upstream during WAIT, so the request stays stable
    assign active       = (state == S_WAIT) || (access && !misaligned);
    assign dmem_req     = active;
    assign stall_m      = active && !dmem_ready;
    assign misaligned_m = (state == S_IDLE) && misaligned;
    assign dmem_we      = active && mem_write_m;
    assign dmem_addr    = {alu_result_m[31:2], 2'b00};

    always_comb begin
        dmem_wdata = 32'h0;
        dmem_be    = 4'b0000;
        if (dmem_we) begin
            case (funct3_m[1:0])
                2'b00: begin
                    dmem_wdata = {4{write_data_m[7:0]}};
                    dmem_be    = 4'b0001 << a;
                end
                2'b01: begin
                    dmem_wdata = {2{write_data_m[15:0]}};
                    dmem_be    = 4'b0011 << a;
                end
                default: begin
                    dmem_wdata = write_data_m;
                    dmem_be    = 4'b1111;
                end
            endcase
        end
    end

    assign shifted = dmem_rdata >> {a, 3'b000};

    always_comb begin
        case (funct3_m)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
            alu_result_w <= 32'h0;
            read_data_w  <= 32'h0;
            pc_plus_4_w  <= 32'h0;
            rd_w         <= 5'd0;
        end else if (active && !dmem_ready) begin
            state       <= S_WAIT;
            reg_write_w <= 1'b0;
            rd_w        <= 5'd0;
        end else begin
            state        <= S_IDLE;
            reg_write_w  <= reg_write_m && !misaligned_m;
            result_src_w <= result_src_m;
            alu_result_w <= alu_result_m;
            read_data_w  <= (active && is_load) ? load_data : 32'h0;
            pc_plus_4_w  <= pc_plus_4_m;
            rd_w         <= rd_m;
        end
    end
endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory stage of the five-stage RV32I pipeline together with the MEM/WB pipeline register. It takes the registered EX/MEM control and data, performs load/store accesses on a ready/valid data-memory port, and byte-aligns and extends load data. It stalls the pipeline while memory wait states are pending, then presents `reg_write_w`, `result_src_w`, `alu_result_w`, `read_data_w`, `pc_plus_4_w` and `rd_w` to the write-back stage.

## Interface
- Clocking (already decided): one clock; reset is synchronous and active-low.
- No parameters; XLEN fixed at 32.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `reg_write_m` in 1; `result_src_m` in 2 (00 ALU, 01 load, 10 PC+4); `mem_write_m` in 1; `funct3_m` in 3.
- `alu_result_m` in 32 (also the effective address); `write_data_m` in 32; `rd_m` in 5; `pc_plus_4_m` in 32.
- `dmem_req` out 1; `dmem_we` out 1; `dmem_addr` out 32 (word-aligned, bits[1:0]=0); `dmem_wdata` out 32; `dmem_be` out 4.
- `dmem_ready` in 1; `dmem_rdata` in 32 (valid only when `dmem_ready`=1).
- `stall_m` out 1: freezes PC, IF/ID, ID/EX and EX/MEM.
- `misaligned_m` out 1: one-cycle flag for a suppressed access.
- `reg_write_w` out 1; `result_src_w` out 2; `alu_result_w` out 32; `read_data_w` out 32; `pc_plus_4_w` out 32; `rd_w` out 5.

## Operation
- Access condition: `result_src_m`=01 (load) or `mem_write_m`=1. Both true together is illegal and is treated as a store.
- Alignment is checked with `a` = `alu_result_m[1:0]`:
  - Misaligned if half (funct3[1:0]=01) with a[0]=1, or word (10) with a≠0.
  - A misaligned access issues no request, sets `misaligned_m`=1 for that cycle and writes `reg_write_w`=0 into MEM/WB.
- Store lanes:
  - SB: `dmem_wdata` = byte replicated ×4, `dmem_be` = 0001<<a.
  - SH: `dmem_wdata` = half replicated ×2, `dmem_be` = 0011<<a.
  - SW: `dmem_wdata` = `write_data_m`, `dmem_be` = 1111.
  - Loads drive `dmem_be` = 0000 and `dmem_we` = 0.
- Load extract: select the byte/half of `dmem_rdata` at offset a.
  - LB (000) / LH (001) sign-extend; LBU (100) / LHU (101) zero-extend; LW (010) passes the word through.
  - Any other funct3 on a load is treated as LW.
- FSM states: IDLE, WAIT.
  - IDLE, no access: MEM/WB captures the EX/MEM values with `read_data_w`=0 and `stall_m`=0.
  - IDLE, aligned access: `dmem_req`=1 combinationally.
    - `dmem_ready`=1 in the same cycle: zero-wait completion. MEM/WB captures (loads capture the extracted data); stay in IDLE.
    - Otherwise: `stall_m`=1, go to WAIT.
  - WAIT: hold `dmem_req`, `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` stable and keep `stall_m`=1.
    - While `dmem_ready`=0, MEM/WB loads a bubble (`reg_write_w`=0, `rd_w`=0, other fields unchanged).
    - On `dmem_ready`=1: `stall_m`=0, MEM/WB captures the instruction, return to IDLE.
- Upstream holds all `*_m` inputs stable while `stall_m`=1. This block does not re-sample them in WAIT.
- `dmem_req` deasserts in the cycle after completion unless the next instruction is also an access. Back-to-back accesses run with no dead cycle.

## Timing
- Reset (`rst_n`=0 at a rising edge): state IDLE; all MEM/WB outputs 0; `dmem_req`, `stall_m` and `misaligned_m` are 0 from the next cycle onward.
- Reset has priority over everything, including mid-WAIT. An outstanding request is abandoned, and a late `dmem_ready` after reset is ignored.
- Latency from EX/MEM to MEM/WB outputs is 1 cycle for non-access and zero-wait accesses, and 1+N cycles for N wait states.
- `stall_m` is combinational from state and `dmem_ready`, with no register.
- Each access produces exactly one MEM/WB capture. No duplicate write-back and no lost write-back.
- `dmem_ready` while `dmem_req`=0 is ignored.

## Test plan
- Reset mid-WAIT: assert `rst_n`=0 during WAIT → next cycle state IDLE, `dmem_req`=0, `reg_write_w`=0, all W outputs 0; a subsequent `dmem_ready` pulse has no effect.
- Zero-wait loads, `dmem_rdata`=0x8081_82F0 with `dmem_ready` tied high:
  - LB at addr 0x100 → `read_data_w`=0xFFFF_FFF0.
  - LBU at addr 0x103 → 0x0000_0080.
  - LH at addr 0x102 → 0xFFFF_8081.
  - In each case `stall_m` is never 1.
- Stores: SB of 0x1234_56AB at addr 0x201 → `dmem_be`=0010, `dmem_wdata`=0xABAB_ABAB, `dmem_addr`=0x200. SH at addr 0x202 → `dmem_be`=1100. SW → `dmem_be`=1111.
- Wait states: LW with `dmem_ready` low for 3 cycles →
  - `stall_m`=1 for exactly 3 cycles, request signals stable throughout.
  - 3 bubbles with `reg_write_w`=0, then one capture with `reg_write_w`=1 and the correct `rd_w`/`read_data_w`.
- Misaligned: LW at addr 0x102 → `dmem_req`=0, `misaligned_m`=1 for 1 cycle, `reg_write_w`=0. SH at addr 0x103 → same behaviour.
- Back-to-back: store then load, each with 1 wait state → `dmem_req` continuously high, two completions, W captures in order, no dead cycle between them.
